// File: rtl/branch_resolver_if.sv
// Signal bundle between fetch/execute and the branch resolver.
// The master side issues predictions and resolutions; the slave side is the resolver.
interface branch_resolver_if #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
);
  localparam int COUNT_W = $clog2(DEPTH) + 1;

  logic               en;
  logic               push;
  logic [ADDR_W-1:0]  push_pc;
  logic [ADDR_W-1:0]  push_pc_4;
  logic [ADDR_W-1:0]  push_guess;
  logic               full;
  logic               res_valid;
  logic               res_is_branch;
  logic               res_jump;
  logic               res_taken;
  logic [ADDR_W-1:0]  res_target;
  logic               flush;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               upd_en;
  logic [ADDR_W-1:0]  upd_pc;
  logic [ADDR_W-1:0]  upd_target;
  logic               upd_succeed;
  logic [COUNT_W-1:0] count;
  logic [CNT_W-1:0]   mispredict_cnt;
  logic               underflow;

  modport master (
    output en, push, push_pc, push_pc_4, push_guess,
    output res_valid, res_is_branch, res_jump, res_taken, res_target,
    input  full, flush, redirect_pc, upd_en, upd_pc, upd_target,
    input  upd_succeed, count, mispredict_cnt, underflow
  );

  modport slave (
    input  en, push, push_pc, push_pc_4, push_guess,
    input  res_valid, res_is_branch, res_jump, res_taken, res_target,
    output full, flush, redirect_pc, upd_en, upd_pc, upd_target,
    output upd_succeed, count, mispredict_cnt, underflow
  );
endinterface

// File: rtl/branch_resolver.sv
// In-order queue of fetch-time predictions; checks each against the execute-stage
// resolution, raises a registered flush/redirect on mismatch and drives BHT updates.
module branch_resolver #(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input logic              clk,
  input logic              rst,
  branch_resolver_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int COUNT_W = PTR_W + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_4;
    logic [ADDR_W-1:0] guess;
  } entry_t;

  entry_t             mem_q [DEPTH];

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               flush_q, flush_d;
  logic [ADDR_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic               upd_en_q, upd_en_d;
  logic [ADDR_W-1:0]  upd_pc_q, upd_pc_d;
  logic [ADDR_W-1:0]  upd_target_q, upd_target_d;
  logic               upd_succeed_q, upd_succeed_d;
  logic               underflow_q, underflow_d;
  logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;

  entry_t             head_entry;
  entry_t             push_entry;
  logic               is_full;
  logic               taken;
  logic [ADDR_W-1:0]  actual;
  logic               resolve;
  logic               mis;
  logic               do_push;

  assign is_full = (count_q == COUNT_W'(DEPTH));

  // Resolution decode on the head entry
  // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    head_entry = mem_q[head_q];
    push_entry = '{pc: bus.push_pc, pc_4: bus.push_pc_4, guess: bus.push_guess};
    taken      = bus.res_jump || (bus.res_is_branch && bus.res_taken);
    actual     = taken ? bus.res_target : head_entry.pc_4;
    resolve    = bus.en && bus.res_valid && (count_q != '0);
    mis        = resolve && (actual != head_entry.guess);
    // A push in a flushing cycle is wrong-path fetch; a full queue only accepts alongside a pop.
    do_push    = bus.en && bus.push && !mis && (!is_full || resolve);
  end

  // Next-state for pointers, occupancy and registered outputs
  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    flush_d       = mis;
    redirect_pc_d = redirect_pc_q;
    upd_en_d      = resolve && (bus.res_is_branch || bus.res_jump);
    upd_pc_d      = upd_pc_q;
    upd_target_d  = upd_target_q;
    upd_succeed_d = upd_succeed_q;
    underflow_d   = bus.en && bus.res_valid && (count_q == '0);
    mis_cnt_d     = mis_cnt_q;

    if (mis) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (resolve) head_d = head_q + 1'b1;
      if (do_push) tail_d = tail_q + 1'b1;
      count_d = count_q + COUNT_W'(do_push) - COUNT_W'(resolve);
    end

    if (resolve) begin
      redirect_pc_d = actual;
      upd_pc_d      = head_entry.pc;
      upd_target_d  = bus.res_target;
      upd_succeed_d = taken;
    end

    if (mis && (mis_cnt_q != {CNT_W{1'b1}})) begin
      mis_cnt_d = mis_cnt_q + 1'b1;
    end
  end

  // NOTE: the prediction storage has no reset; occupancy gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem_q[tail_q] <= push_entry;
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      flush_q       <= 1'b0;
      redirect_pc_q <= '0;
      upd_en_q      <= 1'b0;
      upd_pc_q      <= '0;
      upd_target_q  <= '0;
      upd_succeed_q <= 1'b0;
      underflow_q   <= 1'b0;
      mis_cnt_q     <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      flush_q       <= flush_d;
      redirect_pc_q <= redirect_pc_d;
      upd_en_q      <= upd_en_d;
      upd_pc_q      <= upd_pc_d;
      upd_target_q  <= upd_target_d;
      upd_succeed_q <= upd_succeed_d;
      underflow_q   <= underflow_d;
      mis_cnt_q     <= mis_cnt_d;
    end
  end

  assign bus.full           = is_full;
  assign bus.count          = count_q;
  assign bus.flush          = flush_q;
  assign bus.redirect_pc    = redirect_pc_q;
  assign bus.upd_en         = upd_en_q;
  assign bus.upd_pc         = upd_pc_q;
  assign bus.upd_target     = upd_target_q;
  assign bus.upd_succeed    = upd_succeed_q;
  assign bus.underflow      = underflow_q;
  assign bus.mispredict_cnt = mis_cnt_q;
endmodule
